bist_pattern_sequencer: RTL and testbench
=========================================

# bist_pattern_sequencer

Stimulus and golden-value source for the STRAIT BISC self-test path. On a start pulse it issues `N_VECTORS` operand pairs to the datapath under test, reads the matching golden word from the expected-value ROM, and delays it so `expected` and `exp_valid` arrive on the same cycle as the corresponding datapath result at the main comparator. It reports `busy` while vectors are in flight and `done` once the last result has reached the comparator.

## Interface

Parameters:

- `DATA_W`, 32, operand and expected word width.
- `N_VECTORS`, 64, vectors per run; range 1..2**`ADDR_W`.
- `ADDR_W`, 6, ROM address width.
- `DUT_LATENCY`, 3, cycles from operand issue to result at comparator input; must be ≥1.
- `SEED`, 32'hACE1_0001, LFSR seed; must be nonzero.

Ports:

- `clk`, in, 1, clock.
- `rst`, in, 1, reset; asynchronous, active-high.
- `start`, in, 1, single-cycle run request.
- `pattern_a`, out, `DATA_W`, operand A to the datapath.
- `pattern_b`, out, `DATA_W`, operand B to the datapath.
- `stim_valid`, out, 1, operands valid this cycle.
- `rom_addr`, out, `ADDR_W`, expected-ROM address.
- `rom_data`, in, `DATA_W`, ROM read data, valid 1 cycle after `rom_addr`.
- `expected`, out, `DATA_W`, golden word aligned to the datapath result.
- `exp_valid`, out, 1, `expected` is meaningful this cycle.
- `busy`, out, 1, run in progress.
- `done`, out, 1, run complete; level signal.

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → RUN.
  - Vector index `idx` is cleared to 0 and the LFSR is loaded with `SEED`.
- RUN: each cycle issues vector `idx`.
  - `stim_valid`=1, `rom_addr`=`idx`, patterns from the generator.
  - `idx` increments every cycle and the generator advances.
  - After issuing `idx`=`N_VECTORS`-1 → DRAIN, with a drain counter loaded to `DUT_LATENCY`.
- DRAIN:
  - `stim_valid`=0.
  - The counter decrements each cycle; on reaching 0 → DONE.
- DONE:
  - `done`=1 until the next `start`.
  - `start` → RUN, with the same reload as in IDLE.
- `start` is ignored in RUN and DRAIN.
- `busy`=1 exactly in RUN and DRAIN.
- Expected path:
  - `stim_valid` feeds a shift register of length `DUT_LATENCY`.
  - `rom_data` feeds a register chain of length `DUT_LATENCY`-1, since the ROM already supplies 1 cycle.
  - Their outputs drive `exp_valid` and `expected`.
- When `exp_valid`=0, `expected` is forced to 0. The comparator treats an all-zero result as "no data", and every golden word in the ROM is nonzero.
- When `stim_valid`=0, `pattern_a` and `pattern_b` hold 0.
- `idx` is `ADDR_W`+1 bits wide, and its compare is against `N_VECTORS`-1. `rom_addr` is the low `ADDR_W` bits, so there is no wrap inside a run.

## Timing

- Reset values:
  - State: IDLE.
  - All outputs 0: `pattern_a`, `pattern_b`, `stim_valid`, `rom_addr`, `expected`, `exp_valid`, `busy`, `done`.
  - Delay chains and `idx` cleared.
- Cycle map, with `start` sampled high at edge T:
  - First `stim_valid` at T+1.
  - Vector k is issued at T+1+k.
  - Its `expected`/`exp_valid` appear at T+1+k+`DUT_LATENCY`.
- Last `exp_valid` is at T+`N_VECTORS`+`DUT_LATENCY`.
- `done` rises on the cycle after the last `exp_valid`.
- `busy` falls on the same edge that `done` rises.
- Throughput: one vector per cycle with no bubbles.
- `N_VECTORS`=1: RUN lasts exactly one cycle.
- Reset mid-run: everything returns to reset values immediately, and no further `exp_valid` is produced.

## Configuration

- `BIST_LFSR_EN` defined:
  - Operands come from a 32-bit Galois LFSR with taps 32'h8020_0003, seeded with `SEED` and stepped once per issued vector.
  - `pattern_a` = lfsr.
  - `pattern_b` = {lfsr[15:0], lfsr[31:16]}.
- `BIST_LFSR_EN` undefined:
  - Counter patterns; no LFSR is instantiated.
  - `pattern_a` = `idx`+1, zero-extended.
  - `pattern_b` = ~(`idx`+1).
- The ROM image must be generated for the matching mode.

## Structure

- Shared package `bist_pkg` holds:
  - The FSM state enum: IDLE, RUN, DRAIN, DONE.
  - `LFSR_TAPS` = 32'h8020_0003.
  - `DEFAULT_SEED`.
- One sub-module, `bist_lfsr32`, with ports clk, rst, load, seed, step, and value. It is instantiated only under `BIST_LFSR_EN`.

## Test plan

Bench configuration: `N_VECTORS`=4, `DUT_LATENCY`=3, ROM[i]=32'h1000_0000+i, and the datapath modelled as a 3-cycle delay.

- Start at T:
  - `stim_valid` is high at T+1..T+4 with `rom_addr` 0,1,2,3.
  - `exp_valid` is high at T+4..T+7 with `expected` 32'h1000_0000..32'h1000_0003.
  - `done` rises at T+8.
- Counter mode (no macro): `pattern_a` = 1,2,3,4 and `pattern_b` = 32'hFFFF_FFFE..32'hFFFF_FFFB.
- `BIST_LFSR_EN`:
  - First `pattern_a` = 32'hACE1_0001 and first `pattern_b` = 32'h0001_ACE1.
  - Second `pattern_a` equals one Galois step of the seed.
- `start` pulsed again at T+2: ignored; there are exactly 4 issues and 4 `exp_valid` cycles.
- `rst` asserted at T+3:
  - All outputs read 0 during reset.
  - After release the state is IDLE and no `exp_valid` appears.
  - A new `start` runs a full 4-vector sequence.
- `N_VECTORS`=1: one issue at T+1, `exp_valid` at T+4, `done` at T+5; back-to-back `start` in DONE repeats the run identically.

Source files
------------

// File: rtl/bist_pattern_sequencer_pkg.sv
// Shared types and constants for the BIST pattern sequencer and its LFSR.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

    // Right-shifting Galois step: feedback bit is the LSB shifted out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/bist_pattern_sequencer_if.sv
// Stimulus/golden-value bundle between the BIST sequencer (master) and the
// datapath, expected-ROM and comparator side (slave).
interface bist_pattern_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) ();
    logic              start;
    logic [DATA_W-1:0] pattern_a;
    logic [DATA_W-1:0] pattern_b;
    logic              stim_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] expected;
    logic              exp_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, rom_data,
        output pattern_a, pattern_b, stim_valid, rom_addr,
               expected, exp_valid, busy, done
    );

    modport slave (
        output start, rom_data,
        input  pattern_a, pattern_b, stim_valid, rom_addr,
               expected, exp_valid, busy, done
    );
endinterface

// File: rtl/bist_pattern_sequencer_lfsr32.sv
// 32-bit Galois LFSR operand generator; load has priority over step.
module bist_lfsr32
    import bist_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);
    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/bist_pattern_sequencer.sv
// BIST stimulus sequencer: issues N_VECTORS operand pairs and aligns ROM golden
// words to the datapath result. Define BIST_LFSR_EN for LFSR operands.
module bist_pattern_sequencer
    import bist_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          N_VECTORS   = 64,
    parameter int          ADDR_W      = 6,
    parameter int          DUT_LATENCY = 3,
    parameter logic [31:0] SEED        = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    bist_pattern_sequencer_if.master bus
);
    localparam int                CNT_W      = $clog2(DUT_LATENCY + 1);
    localparam logic [ADDR_W:0]   LAST_IDX   = (ADDR_W + 1)'(N_VECTORS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DUT_LATENCY);

    bist_state_e             state_q, state_d;
    logic [ADDR_W:0]         idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    stim_valid_q, stim_valid_d;
    logic [DATA_W-1:0]       pattern_a_q, pattern_a_d;
    logic [DATA_W-1:0]       pattern_b_q, pattern_b_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DUT_LATENCY-1:0]  vld_q, vld_d;
    logic                    issue;
    logic [DATA_W-1:0]       exp_raw;

`ifdef BIST_LFSR_EN
    logic [31:0] lfsr_value;

    // Reloaded with the seed whenever no vector is issued, so every run starts fresh.
    bist_lfsr32 #(.RESET_VAL(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (!issue),
        .seed  (SEED),
        .step  (issue),
        .value (lfsr_value)
    );
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                idx_d = '0;
                if (bus.start) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    idx_d = idx_q + (ADDR_W + 1)'(1);
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        stim_valid_d = issue;
        pattern_a_d  = '0;
        pattern_b_d  = '0;
        if (issue) begin
`ifdef BIST_LFSR_EN
            pattern_a_d = DATA_W'(lfsr_value);
            pattern_b_d = DATA_W'({lfsr_value[15:0], lfsr_value[31:16]});
`else
            pattern_a_d = DATA_W'(idx_d) + DATA_W'(1);
            pattern_b_d = ~(DATA_W'(idx_d) + DATA_W'(1));
`endif
        end
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);

        vld_d[0] = stim_valid_q;
        for (int i = 1; i < DUT_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            stim_valid_q <= 1'b0;
            pattern_a_q  <= '0;
            pattern_b_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vld_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            stim_valid_q <= stim_valid_d;
            pattern_a_q  <= pattern_a_d;
            pattern_b_q  <= pattern_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vld_q        <= vld_d;
        end
    end

    // The ROM read already costs one cycle, so the data chain is one stage shorter.
    if (DUT_LATENCY > 1) begin : g_dat
        logic [DATA_W-1:0] dat_q [DUT_LATENCY-1];
        logic [DATA_W-1:0] dat_d [DUT_LATENCY-1];

        always_comb begin
            dat_d[0] = bus.rom_data;
            for (int i = 1; i < DUT_LATENCY - 1; i++) begin
                dat_d[i] = dat_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DUT_LATENCY - 1; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                dat_q <= dat_d;
            end
        end

        assign exp_raw = dat_q[DUT_LATENCY-2];
    end else begin : g_nodat
        assign exp_raw = bus.rom_data;
    end

    assign bus.pattern_a  = pattern_a_q;
    assign bus.pattern_b  = pattern_b_q;
    assign bus.stim_valid = stim_valid_q;
    assign bus.rom_addr   = idx_q[ADDR_W-1:0];
    assign bus.exp_valid  = vld_q[DUT_LATENCY-1];
    // All-zero means "no data" at the comparator, so idle cycles must read zero.
    assign bus.expected   = vld_q[DUT_LATENCY-1] ? exp_raw : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bist_pattern_sequencer.sv
// Randomized start/reset stimulus on two sequencers (4 vectors and 1 vector),
// checked cycle by cycle against an offset-from-start reference model.
module tb_bist_pattern_sequencer;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;

    always #5 clk = ~clk;

    bist_pattern_sequencer_if #(.DATA_W(32), .ADDR_W(6)) if0 ();
    bist_pattern_sequencer_if #(.DATA_W(32), .ADDR_W(6)) if1 ();

    bist_pattern_sequencer #(
        .DATA_W(32), .N_VECTORS(4), .ADDR_W(6), .DUT_LATENCY(LAT), .SEED(32'hACE1_0001)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    bist_pattern_sequencer #(
        .DATA_W(32), .N_VECTORS(1), .ADDR_W(6), .DUT_LATENCY(LAT), .SEED(32'hACE1_0001)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    assign if0.start = start;
    assign if1.start = start;

    // Expected-value ROMs with a one-cycle registered read.
    always @(posedge clk) if0.rom_data <= 32'h1000_0000 + {26'd0, if0.rom_addr};
    always @(posedge clk) if1.rom_data <= 32'h1000_0000 + {26'd0, if1.rom_addr};

    // Datapath stand-in: operand valid delayed by the datapath latency.
    logic [LAT-1:0] dpv0, dpv1;
    always @(posedge clk or posedge rst) begin
        if (rst) dpv0 <= '0;
        else     dpv0 <= {dpv0[LAT-2:0], if0.stim_valid};
    end
    always @(posedge clk or posedge rst) begin
        if (rst) dpv1 <= '0;
        else     dpv1 <= {dpv1[LAT-2:0], if1.stim_valid};
    end

    logic [31:0] o_pa [2];
    logic [31:0] o_pb [2];
    logic [31:0] o_exp [2];
    logic [5:0]  o_addr [2];
    logic        o_sv [2];
    logic        o_ev [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic        o_dp [2];

    assign o_pa[0] = if0.pattern_a;   assign o_pa[1] = if1.pattern_a;
    assign o_pb[0] = if0.pattern_b;   assign o_pb[1] = if1.pattern_b;
    assign o_exp[0] = if0.expected;   assign o_exp[1] = if1.expected;
    assign o_addr[0] = if0.rom_addr;  assign o_addr[1] = if1.rom_addr;
    assign o_sv[0] = if0.stim_valid;  assign o_sv[1] = if1.stim_valid;
    assign o_ev[0] = if0.exp_valid;   assign o_ev[1] = if1.exp_valid;
    assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;
    assign o_done[0] = if0.done;      assign o_done[1] = if1.done;
    assign o_dp[0] = dpv0[LAT-1];     assign o_dp[1] = dpv1[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_cyc  = 0;

    // Reference model: run state is just "cycles elapsed since the accepted start".
    int nv [2] = '{4, 1};
    bit hr [2];
    int d  [2];
    logic [31:0] lfsr_seq [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic check_outputs(input int i);
        bit          busy_e, stim_e, ev_e, done_e;
        logic [31:0] pa_e, pb_e, exp_e;
        int          k;
        busy_e = hr[i] && d[i] >= 1 && d[i] <= nv[i] + LAT;
        stim_e = hr[i] && d[i] >= 1 && d[i] <= nv[i];
        ev_e   = hr[i] && d[i] > LAT && d[i] <= nv[i] + LAT;
        done_e = hr[i] && d[i] > nv[i] + LAT;
        k      = d[i] - 1;
        pa_e   = '0;
        pb_e   = '0;
        if (stim_e) begin
`ifdef BIST_LFSR_EN
            pa_e = lfsr_seq[k];
            pb_e = {lfsr_seq[k][15:0], lfsr_seq[k][31:16]};
`else
            pa_e = 32'(k + 1);
            pb_e = ~32'(k + 1);
`endif
            check($sformatf("i%0d.rom_addr", i), 64'(o_addr[i]), 64'(k));
        end
        exp_e = ev_e ? 32'h1000_0000 + 32'(d[i] - 1 - LAT) : 32'h0;
        check($sformatf("i%0d.stim_valid", i), 64'(o_sv[i]),   64'(stim_e));
        check($sformatf("i%0d.busy", i),       64'(o_busy[i]), 64'(busy_e));
        check($sformatf("i%0d.done", i),       64'(o_done[i]), 64'(done_e));
        check($sformatf("i%0d.exp_valid", i),  64'(o_ev[i]),   64'(ev_e));
        check($sformatf("i%0d.expected", i),   64'(o_exp[i]),  64'(exp_e));
        check($sformatf("i%0d.pattern_a", i),  64'(o_pa[i]),   64'(pa_e));
        check($sformatf("i%0d.pattern_b", i),  64'(o_pb[i]),   64'(pb_e));
        check($sformatf("i%0d.dp_align", i),   64'(o_ev[i]),   64'(o_dp[i]));
    endtask

    task automatic check_reset_zero(input int i);
        check($sformatf("i%0d.rst_outs", i),
              {o_pa[i], o_pb[i] | o_exp[i]} | 64'({o_addr[i], o_sv[i], o_ev[i], o_busy[i], o_done[i]}),
              64'h0);
    endtask

    task automatic model_step();
        bit busy_b;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                hr[i] = 1'b0;
                d[i]  = 0;
            end else begin
                busy_b = hr[i] && d[i] >= 1 && d[i] <= nv[i] + LAT;
                if (start && !busy_b) begin
                    hr[i] = 1'b1;
                    d[i]  = 1;
                end else if (hr[i] && d[i] <= nv[i] + LAT) begin
                    d[i]++;
                    if (d[i] == nv[i] + LAT + 1)
                        $display("run complete: inst %0d (N=%0d) at cycle %0d", i, nv[i], cur_cyc);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        v = 32'hACE1_0001;
        for (int k = 0; k < 4; k++) begin
            lfsr_seq[k] = v;
            v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
        end
        hr    = '{1'b0, 1'b0};
        d     = '{0, 0};
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_zero(0);
        check_reset_zero(1);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            cur_cyc = cyc;
            @(negedge clk);
            check_outputs(0);
            check_outputs(1);
            if (!rst && $urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                #1;
                check_reset_zero(0);
                check_reset_zero(1);
                hr = '{1'b0, 1'b0};
                d  = '{0, 0};
                $display("reset asserted at cycle %0d", cyc);
            end else if (rst) begin
                rst = 1'b0;
            end
            start = !rst && ($urandom_range(0, 4) == 0);
            @(posedge clk);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
